// File: rtl/display_pkg.sv
// display_pkg: shared constants, glyph table, power-of-ten helper and the
// BCD conversion state type for the multiplexed 7-segment display driver.
//   SEG_BLANK / SEG_DASH : special glyphs (active-low, gfedcba)
//   hex_to_seg()         : nibble -> active-low glyph
//   pow10()              : 10**n, used to derive the decimal range limit
//   bcd_state_t          : IDLE / SHIFT / DONE
package display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational nibble -> active-low 7-segment glyph.
//   i_nibble  in  4  digit value
//   i_blank   in  1  force all segments off
//   i_dash    in  1  force the dash glyph (takes priority over blanking)
//   o_seg     out 7  active-low segments, bit6..0 = g f e d c b a
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_seg
);

    always_comb begin
        if (i_dash) begin
            o_seg = SEG_DASH;
        end else if (i_blank) begin
            o_seg = SEG_BLANK;
        end else begin
            o_seg = hex_to_seg(i_nibble);
        end
    end

endmodule

// File: rtl/display_mux_driver.sv
// display_mux_driver: time-multiplexed N-digit 7-segment driver, hex or decimal.
//   clk, rst_n   clock (rising) / asynchronous active-low reset
//   load_i       strobe: capture value_i and dec_mode_i (ignored while busy_o)
//   value_i      unsigned value to display
//   dec_mode_i   1 = decimal via serial shift-add-3, 0 = hex
//   blank_lz_i   blank leading zero digits (live)
//   enable_i     0 = all digit enables off, scanning continues
//   busy_o       decimal conversion in progress
//   ovf_o        last decimal load was out of range
//   seg_o        active-low segments gfedcba
//   an_o         active-low one-hot digit enable, an_o[0] = least significant
module display_mux_driver
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [DATA_W-1:0]     value_i,
    input  logic                  dec_mode_i,
    input  logic                  blank_lz_i,
    input  logic                  enable_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    output logic [6:0]            seg_o,
    output logic [NUM_DIGITS-1:0] an_o
);

    localparam int unsigned     BCD_W   = 4 * NUM_DIGITS;
    localparam int unsigned     IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned     PRESC_W = $clog2(REFRESH_DIV);
    localparam int unsigned     CNT_W   = $clog2(DATA_W);
    localparam longint unsigned MAX_DEC = pow10(NUM_DIGITS) - 64'd1;

    logic [PRESC_W-1:0]    r_presc;
    logic [IDX_W-1:0]      r_idx;
    bcd_state_t            r_state, w_next_state;
    logic [DATA_W-1:0]     r_shift;
    logic [BCD_W-1:0]      r_bcd, w_bcd_adj;
    logic [CNT_W-1:0]      r_cnt;
    logic [BCD_W-1:0]      r_disp;
    logic                  r_dash, r_ovf;
    logic [6:0]            r_seg, w_seg;
    logic [NUM_DIGITS-1:0] r_an, w_an, w_lz_mask;
    logic                  w_presc_wrap, w_dec_ovf, w_busy, w_seen;
    logic [3:0]            w_cur_nib;
    int unsigned           w_k;

    assign w_presc_wrap = (r_presc == PRESC_W'(REFRESH_DIV - 1));
    assign w_dec_ovf    = (64'(value_i) > MAX_DEC);

    // Prescaler and scan index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (load_i && dec_mode_i && !w_dec_ovf) w_next_state = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(DATA_W - 1)) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        w_busy = 1'b0;
        if (r_state != IDLE) w_busy = 1'b1;
    end

    // Double-dabble correction: add 3 to every BCD nibble >= 5 before shifting
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) w_bcd_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
        end
    end

    // Load capture, conversion datapath and display register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_disp  <= '0;
            r_dash  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load_i) begin
                        if (!dec_mode_i) begin
                            r_disp <= BCD_W'(value_i);
                            r_dash <= 1'b0;
                            r_ovf  <= 1'b0;
                        end else if (w_dec_ovf) begin
                            r_dash <= 1'b1;
                            r_ovf  <= 1'b1;
                        end else begin
                            r_ovf   <= 1'b0;
                            r_shift <= value_i;
                            r_bcd   <= '0;
                            r_cnt   <= '0;
                        end
                    end
                end
                SHIFT: begin
                    r_bcd   <= (w_bcd_adj << 1) | BCD_W'(r_shift[DATA_W-1]);
                    r_shift <= r_shift << 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                end
                DONE: begin
                    r_disp <= r_bcd;
                    r_dash <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Leading-zero mask: walk from the top digit down until a nonzero nibble
    always_comb begin
        w_lz_mask = '0;
        w_seen    = 1'b0;
        w_k       = 0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            w_k = NUM_DIGITS - 1 - j;
            if (r_disp[4*w_k +: 4] != 4'd0) w_seen = 1'b1;
            w_lz_mask[w_k] = blank_lz_i && !w_seen && (w_k != 0);
        end
    end

    assign w_cur_nib = r_disp[4*r_idx +: 4];

    seg7_decode u_decode (
        .i_nibble (w_cur_nib),
        .i_blank  (w_lz_mask[r_idx]),
        .i_dash   (r_dash),
        .o_seg    (w_seg)
    );

    always_comb begin
        w_an = '1;
        for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
            w_an[d] = !(enable_i && (r_idx == IDX_W'(d)));
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= '1;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
        end
    end

    assign busy_o = w_busy;
    assign ovf_o  = r_ovf;
    assign seg_o  = r_seg;
    assign an_o   = r_an;

endmodule
